param_dcache: RTL
=================

PARAM_DCACHE -- requirements
Module: param_dcache

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, meaning associativity; a power of two, 2..8.
REQ-002 The block SHALL have parameter SETS, default 16, meaning set count; a power of two, 2..64.
REQ-003 The block SHALL have parameter LINE_BYTES, default 32, meaning line size; 32 or 64; dfp data width = 8*LINE_BYTES.
REQ-004 The block SHALL have a port clk, input, 1, the single clock; all state is on the rising edge.
REQ-005 The block SHALL have a port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have a port ufp_addr, input, 32, CPU byte address; word-aligned.
REQ-007 The block SHALL have ports ufp_rmask and ufp_wmask, input, 4 each, byte read and byte write enables; nonzero marks a request.
REQ-008 The block SHALL have a port ufp_wdata, input, 32, store data.
REQ-009 The block SHALL have a port ufp_rdata, output, 32, load data; valid only while ufp_resp is high.
REQ-010 The block SHALL have a port ufp_resp, output, 1, a single-cycle completion pulse.
REQ-011 The block SHALL have a port dfp_addr, output, 32, line-aligned memory address.
REQ-012 The block SHALL have ports dfp_read and dfp_write, output, 1 each, memory requests; these are never high together.
REQ-013 The block SHALL have a port dfp_wdata, output, 8*LINE_BYTES, victim line.
REQ-014 The block SHALL have a port dfp_rdata, input, 8*LINE_BYTES, fill line.
REQ-015 The block SHALL have a port dfp_resp, input, 1, memory completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, COMPARE, WRITEBACK, ALLOCATE, with index=addr[log2(LINE_BYTES)+:log2(SETS)] and tag=remaining upper bits.
REQ-017 IDLE->COMPARE SHALL occur when rmask|wmask is nonzero; ufp inputs are held stable by the requester until ufp_resp.
REQ-018 A COMPARE hit SHALL assert ufp_resp in that cycle (one cycle after IDLE saw the request) with ufp_rdata=hit word, update PLRU to mark the way MRU, and go to IDLE.
REQ-019 A write hit SHALL merge wmask bytes into the line at the next edge and set that way's dirty bit; when rmask and wmask are both nonzero the request is a write and ufp_rdata returns the pre-write word.
REQ-020 On a miss, the victim SHALL be the lowest-index invalid way if any, else the tree-PLRU way (WAYS-1 bits per set).
REQ-021 On a miss with a valid and dirty victim: COMPARE->WRITEBACK (dfp_write=1, dfp_addr={victim tag,index,0}, dfp_wdata=victim line) until dfp_resp, then ->ALLOCATE; otherwise COMPARE->ALLOCATE directly.
REQ-022 ALLOCATE SHALL hold dfp_read=1 with dfp_addr={tag,index,0}; on dfp_resp it writes the line, sets the tag, valid=1 and dirty=0, then ->COMPARE, and the re-lookup hits.
REQ-023 The victim way SHALL be latched on COMPARE exit and remain fixed through WRITEBACK/ALLOCATE.
REQ-024 dfp_resp SHALL be ignored when neither dfp_read nor dfp_write is asserted.
REQ-025 dfp outputs SHALL be stable while a request is pending; dfp_read/dfp_write drop in the cycle after dfp_resp.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, all valid, dirty and PLRU bits=0, and ufp_resp=dfp_read=dfp_write=0, dfp_addr=0 and dfp_wdata=0, including mid-WRITEBACK/ALLOCATE; the in-flight request is dropped.
REQ-027 Data and tag storage SHALL need no reset.

Configuration
REQ-028 With DCACHE_PERF_CNT_EN defined, the block SHALL add 32-bit output ports hit_count and miss_count; each counts once per request at its first COMPARE, saturates at all-ones, and is reset to 0.
REQ-029 Without DCACHE_PERF_CNT_EN, those ports and the counter logic SHALL be absent.

Structure
REQ-030 Package dcache_pkg SHALL hold the state enum and the localparam helpers for offset, index and tag widths.
REQ-031 Sub-module plru_tree SHALL hold the per-set tree bits, victim lookup and MRU update, parametrised by WAYS and SETS.

Verification
REQ-032 Cold read 0x0000_1004, rmask=F: ALLOCATE with dfp_addr=0x0000_1000; dfp_rdata word1=0xDEADBEEF; ufp_resp with rdata 0xDEADBEEF.
REQ-033 Write hit 0x0000_1004, wmask=3, wdata=0x0000_1234, then a read: rdata 0xDEAD1234 and dirty=1; no dfp traffic.
REQ-034 Fill the same set with WAYS+1 distinct tags, dirty line LRU: WRITEBACK to the old tag address with the merged line, then ALLOCATE.
REQ-035 Assert rst during ALLOCATE before dfp_resp: dfp_read falls immediately, and the next read of the same address misses.
REQ-036 WAYS=2, SETS=64, LINE_BYTES=64 build: repeat REQ-032..034; with DCACHE_PERF_CNT_EN, after 1 miss and 3 hits hit_count=3 and miss_count=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and address-field width helpers for param_dcache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } dcache_state_e;

    function automatic int offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int line_bytes, input int sets);
        return 32 - offset_bits(line_bytes) - index_bits(sets);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - per-set tree pseudo-LRU bits with victim lookup and MRU update
module plru_tree
    import dcache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [index_bits(SETS)-1:0] lookup_set,
    output logic [$clog2(WAYS)-1:0]      victim,
    input  logic                         update_en,
    input  logic [index_bits(SETS)-1:0] update_set,
    input  logic [$clog2(WAYS)-1:0]      update_way
);

    localparam int LV = $clog2(WAYS);
    localparam int NB = WAYS - 1;

    // Heap-ordered nodes: children of n are 2n+1 / 2n+2; a 0 bit points left toward the LRU side.
    logic [NB-1:0] tree_q [SETS];
    logic [NB-1:0] cur;
    logic [NB-1:0] upd;

    always_comb begin
        int   node;
        logic b;
        cur    = tree_q[lookup_set];
        victim = '0;
        node   = 0;
        for (int l = 0; l < LV; l++) begin
            b = 1'b0;
            for (int n = 0; n < NB; n++)
                if (n == node) b = cur[n];
            victim = LV'({victim, b});
            node   = 2 * node + 1 + int'(b);
        end
    end

    always_comb begin
        int               node;
        logic             b;
        logic [LV-1:0]    w;
        upd  = tree_q[update_set];
        w    = update_way;
        node = 0;
        for (int l = 0; l < LV; l++) begin
            b = w[LV-1];
            w = LV'({w, 1'b0});
            for (int n = 0; n < NB; n++)
                if (n == node) upd[n] = ~b;
            node = 2 * node + 1 + int'(b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (update_en) begin
            tree_q[update_set] <= upd;
        end
    end

endmodule

// File: rtl/param_dcache.sv
// rtl/param_dcache.sv - parameterised write-back set-associative data cache; DCACHE_PERF_CNT_EN adds hit/miss counters
module param_dcache
    import dcache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             ufp_addr,
    input  logic [3:0]              ufp_rmask,
    input  logic [3:0]              ufp_wmask,
    input  logic [31:0]             ufp_wdata,
    output logic [31:0]             ufp_rdata,
    output logic                    ufp_resp,
    output logic [31:0]             dfp_addr,
    output logic                    dfp_read,
    output logic                    dfp_write,
    output logic [8*LINE_BYTES-1:0] dfp_wdata,
    input  logic [8*LINE_BYTES-1:0] dfp_rdata,
    input  logic                    dfp_resp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int OFF = offset_bits(LINE_BYTES);
    localparam int IW  = index_bits(SETS);
    localparam int TW  = tag_bits(LINE_BYTES, SETS);
    localparam int WW  = $clog2(WAYS);
    localparam int LW  = 8 * LINE_BYTES;
    localparam int WSW = OFF - 2;

    dcache_state_e state;
    logic [LW-1:0] data_mem [SETS][WAYS];
    logic [TW-1:0] tag_mem  [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WW-1:0] victim_q;

    logic [IW-1:0]  idx;
    logic [TW-1:0]  tag;
    logic [WSW-1:0] wsel;
    logic           is_req, is_write, hit, victim_dirty;
    logic [WW-1:0]  hit_way, victim, plru_victim;
    logic [LW-1:0]  hit_line, wr_line;
    logic [31:0]    hit_word, new_word;
    logic           unused_addr;

    assign idx         = ufp_addr[OFF +: IW];
    assign tag         = ufp_addr[31 -: TW];
    assign wsel        = ufp_addr[2 +: WSW];
    assign unused_addr = ^ufp_addr[1:0];
    assign is_req      = |(ufp_rmask | ufp_wmask);
    assign is_write    = |ufp_wmask;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign hit_line = data_mem[idx][hit_way];
    assign hit_word = hit_line[{wsel, 5'b0} +: 32];

    always_comb begin
        for (int b = 0; b < 4; b++)
            new_word[b*8 +: 8] = ufp_wmask[b] ? ufp_wdata[b*8 +: 8] : hit_word[b*8 +: 8];
        wr_line = hit_line;
        wr_line[{wsel, 5'b0} +: 32] = new_word;
    end

    // Descending scan so the lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        victim = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = WW'(w);
    end
    assign victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];

    assign ufp_resp  = (state == COMPARE) && hit;
    assign ufp_rdata = hit_word;

    plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk        (clk),
        .rst        (rst),
        .lookup_set (idx),
        .victim     (plru_victim),
        .update_en  (ufp_resp),
        .update_set (idx),
        .update_way (hit_way)
    );

    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && is_write)
            data_mem[idx][hit_way] <= wr_line;
        if (state == ALLOCATE && dfp_read && dfp_resp) begin
            data_mem[idx][victim_q] <= dfp_rdata;
            tag_mem[idx][victim_q]  <= tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic first_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            victim_q  <= '0;
            dfp_read  <= 1'b0;
            dfp_write <= 1'b0;
            dfp_addr  <= '0;
            dfp_wdata <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
`ifdef DCACHE_PERF_CNT_EN
            first_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (is_req) begin
                        state <= COMPARE;
`ifdef DCACHE_PERF_CNT_EN
                        first_q <= 1'b1;
`endif
                    end
                end
                COMPARE: begin
`ifdef DCACHE_PERF_CNT_EN
                    first_q <= 1'b0;
                    if (first_q) begin
                        if (hit) begin
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
                        end else if (miss_count != '1) begin
                            miss_count <= miss_count + 32'd1;
                        end
                    end
`endif
                    if (hit) begin
                        state <= IDLE;
                        if (is_write) dirty_q[idx][hit_way] <= 1'b1;
                    end else begin
                        victim_q <= victim;
                        if (victim_dirty) begin
                            state     <= WRITEBACK;
                            dfp_write <= 1'b1;
                            dfp_addr  <= {tag_mem[idx][victim], idx, {OFF{1'b0}}};
                            dfp_wdata <= data_mem[idx][victim];
                        end else begin
                            state    <= ALLOCATE;
                            dfp_read <= 1'b1;
                            dfp_addr <= {tag, idx, {OFF{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (dfp_write && dfp_resp) begin
                        state     <= ALLOCATE;
                        dfp_write <= 1'b0;
                        dfp_read  <= 1'b1;
                        dfp_addr  <= {tag, idx, {OFF{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (dfp_read && dfp_resp) begin
                        state                   <= COMPARE;
                        dfp_read                <= 1'b0;
                        valid_q[idx][victim_q]  <= 1'b1;
                        dirty_q[idx][victim_q]  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
